// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared limb width, FSM state encoding and index-width helper for mp_add_seq
package mp_add_pkg;
  localparam int LIMB_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int idx_w(input int words);
    return $clog2(words) + 1;
  endfunction
endpackage

// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: request/result handshake bundle of mp_add_seq; MP_ADD_CHAIN_EN adds the chain request bit
interface mp_add_seq_if #(parameter int WORDS = 4);
  localparam int W = 8 * WORDS;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
`ifdef MP_ADD_CHAIN_EN
  logic         chain;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;
  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
`ifdef MP_ADD_CHAIN_EN
    output chain,
`endif
    input  in_ready, out_valid, result, carry, overflow, zero, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
`ifdef MP_ADD_CHAIN_EN
    input  chain,
`endif
    output in_ready, out_valid, result, carry, overflow, zero, busy
  );
endinterface

// File: rtl/adder.sv
// adder: 8-bit adder with carry-in, carry-out and signed overflow (carry into MSB xor carry out of MSB)
module adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CI,
  output logic [7:0] Y,
  output logic       C,
  output logic       V
);
  logic [7:0] w_lo;
  logic [1:0] w_hi;
  assign w_lo = {1'b0, A[6:0]} + {1'b0, B[6:0]} + {7'd0, CI};
  assign w_hi = {1'b0, A[7]} + {1'b0, B[7]} + {1'b0, w_lo[7]};
  assign Y = {w_hi[0], w_lo[6:0]};
  assign C = w_hi[1];
  assign V = w_hi[1] ^ w_lo[7];
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: WORDS-limb add/subtract through one 8-bit adder, LSB limb first; MP_ADD_CHAIN_EN enables carry chaining across ops
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic          clk,
  input logic          rst_n,
  mp_add_seq_if.slave  s
);
  localparam int W  = LIMB_W * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [W-1:0]        r_a, r_b, r_res;
  logic                r_cy, r_carry, r_ovf, r_zero, r_out_valid, r_busy;
  logic [LIMB_W-1:0]   w_la, w_lb, w_y;
  logic                w_c, w_v, w_cin0;
  logic [W-1:0]        w_res_next;
  assign w_la = r_a[LIMB_W*int'(r_idx) +: LIMB_W];
  assign w_lb = r_b[LIMB_W*int'(r_idx) +: LIMB_W];
`ifdef MP_ADD_CHAIN_EN
  assign w_cin0 = s.chain ? r_carry : s.sub;
`else
  assign w_cin0 = s.sub;
`endif
  adder u_adder (.A(w_la), .B(w_lb), .CI(r_cy), .Y(w_y), .C(w_c), .V(w_v));
  // result with the current limb merged in, so the final-limb zero test sees the whole word
  always_comb begin
    w_res_next = r_res;
    w_res_next[LIMB_W*int'(r_idx) +: LIMB_W] = w_y;
  end
  // sequencer: accept, walk limbs through the shared adder, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_cy        <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (s.in_valid) begin
          r_a     <= s.op_a;
          r_b     <= s.op_b ^ {W{s.sub}};
          r_cy    <= w_cin0;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_res <= w_res_next;
          r_cy  <= w_c;
          if (r_idx == LAST) begin
            r_carry     <= w_c;
            r_ovf       <= w_v;
            r_zero      <= (w_res_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: if (s.out_ready) begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign s.in_ready  = (r_state == IDLE);
  assign s.out_valid = r_out_valid;
  assign s.result    = r_res;
  assign s.carry     = r_carry;
  assign s.overflow  = r_ovf;
  assign s.zero      = r_zero;
  assign s.busy      = r_busy;
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for mp_add_seq (WORDS=4); chain cases follow MP_ADD_CHAIN_EN
module tb_mp_add_seq;
  localparam int WORDS = 4;
  localparam int W = 8 * WORDS;
`ifdef MP_ADD_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic m_carry = 1'b0;
  exp_t sb[$];

  mp_add_seq_if #(.WORDS(WORDS)) bus ();
  mp_add_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic cin);
    exp_t m;
    logic [W:0]   f;
    logic [W-1:0] bx;
    bx    = b ^ {W{s}};
    f     = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    m.res = f[W-1:0];
    m.c   = f[W];
    m.v   = (a[W-1] == bx[W-1]) && (f[W-1] != a[W-1]);
    m.z   = (f[W-1:0] == '0);
    return m;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ch);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.op_a = a;
    bus.op_b = b;
    bus.sub  = s;
`ifdef MP_ADD_CHAIN_EN
    bus.chain = ch;
`endif
    bus.in_valid = 1'b1;
    e = model(a, b, s, (ch & CHAIN) ? m_carry : s);
    m_carry = e.c;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, WORDS);
  endtask

  task automatic collect();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("result", bus.result, e.res);
      chk("carry", bus.carry, e.c);
      chk("overflow", bus.overflow, e.v);
      chk("zero", bus.zero, e.z);
    end
    chk("busy_done", bus.busy, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("out_valid_clr", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ch);
    int lat;
    issue(a, b, s, ch);
    wait_out(lat);
    collect();
  endtask

  initial begin
    int lat;
    exp_t e;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.sub = 1'b0;
`ifdef MP_ADD_CHAIN_EN
    bus.chain = 1'b0;
`endif
    #22;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_flags", {bus.carry, bus.overflow, bus.zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h000000FF, 32'h00000001, 0, 0);
    run_op(32'h7FFFFFFF, 32'h00000001, 0, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 0, 0);
    run_op(32'h00000005, 32'h00000005, 1, 0);
    run_op(32'h00000000, 32'h00000001, 1, 0);
    run_op(32'h80000000, 32'h00000001, 1, 0);

    issue(32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0);
    wait_out(lat);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      @(posedge clk);
      #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, e.res);
      chk("hold_flags", {bus.carry, bus.overflow, bus.zero}, {e.c, e.v, e.z});
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    collect();
    repeat (6) @(posedge clk);
    #1;
    chk("no_queued_op", {bus.out_valid, bus.busy}, 0);

    @(negedge clk);
    bus.op_a = 32'hDEADBEEF;
    bus.op_b = 32'h01010101;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    m_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h12345678, 32'h11111111, 0, 0);

    run_op(32'hFFFFFFFF, 32'h00000001, 0, 0);
    run_op(32'h00000000, 32'h00000000, 0, 1);
    run_op(32'hFFFFFFFF, 32'h00000001, 0, 0);
    run_op(32'h00000000, 32'h00000000, 0, 0);

    for (int i = 0; i < 8; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
